alu_arbiter: RTL and testbench

Two-requester front end for the shared 16-bit `alu` datapath. Accepts operations from two independent requesters over valid/ready handshakes, arbitrates round-robin, and drives one operation at a time through an internal `alu` instance. Returns a registered result tagged with the winning requester ID over a valid/ready response channel. Sits between the control unit's issue ports and the single ALU, so the ALU can be shared without duplicating it.

---
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue ports and alu_arbiter.
// master: requester/consumer side. slave: the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one 16-bit alu between two
// requesters. Optional grant counters are built when ALU_ARB_STATS_EN is
// defined; otherwise grant_cnt0/grant_cnt1 are tied to zero.

// Fixed 16-bit combinational ALU datapath.
module alu (
  input  logic [2:0]  sel_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  // Operation select; arithmetic wraps modulo 2^16.
  always_comb begin
    y_o = a_i;
    case (sel_i)
      3'b000:  y_o = a_i + b_i;
      3'b001:  y_o = a_i - b_i;
      3'b010:  y_o = a_i & b_i;
      3'b011:  y_o = a_i | b_i;
      3'b100:  y_o = ~a_i;
      3'b101:  y_o = '0;
      default: y_o = a_i;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [WIDTH-1:0] grant_cnt0,
  output logic [WIDTH-1:0] grant_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] alu_y;
  logic             pick1, grant0, grant1, accept;

  // Arbitration: port 1 wins if it alone is valid, or on contention when
  // port 0 won last. Nothing is granted during reset or outside IDLE.
  always_comb begin
    pick1  = bus.req1_valid && (!bus.req0_valid || !last_q);
    grant0 = (state_q == IDLE) && !rst && bus.req0_valid && !pick1;
    grant1 = (state_q == IDLE) && !rst && pick1;
    accept = grant0 || grant1;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = (state_q != IDLE);

  alu u_alu (
    .sel_i (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .y_o   (alu_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept -> execute -> hold response until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= grant1;
        id_q   <= grant1;
        op_q   <= grant1 ? bus.req1_op : bus.req0_op;
        a_q    <= grant1 ? bus.req1_a  : bus.req0_a;
        b_q    <= grant1 ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_y;
        rsp_id_q   <= id_q;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [WIDTH-1:0] grant_cnt0_q, grant_cnt1_q;

  // Saturating per-port accept counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (grant0 && grant_cnt0_q != '1) grant_cnt0_q <= grant_cnt0_q + 1'b1;
      if (grant1 && grant_cnt1_q != '1) grant_cnt1_q <= grant_cnt1_q + 1'b1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. Inputs are driven and
// outputs sampled on the falling edge. Define ALU_ARB_STATS_EN to check
// the grant counters, otherwise they are checked to read zero.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] gc0, gc1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    check("rst_rsp_data", bus.rsp_data, 16'h0000);
    check("rst_rsp_id", 16'(bus.rsp_id), 16'h0);
    check("rst_gc0", gc0, 16'h0000);
    check("rst_gc1", gc1, 16'h0000);
    rst = 1'b0;
  endtask

  // One isolated operation on a single port with rsp_ready held high.
  task automatic run_op(input logic port, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input string tag);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    check({tag, "_rdy0"}, 16'(bus.req0_ready), 16'(!port));
    check({tag, "_rdy1"}, 16'(bus.req1_ready), 16'(port));
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check({tag, "_exec_busy"}, 16'(busy), 16'h1);
    check({tag, "_exec_vld"}, 16'(bus.rsp_valid), 16'h0);
    @(negedge clk);
    check({tag, "_vld"}, 16'(bus.rsp_valid), 16'h1);
    check({tag, "_data"}, bus.rsp_data, exp);
    check({tag, "_id"}, 16'(bus.rsp_id), 16'(port));
    @(negedge clk);
    check({tag, "_idle"}, 16'(busy), 16'h0);
  endtask

  logic [15:0] sweep_exp [8];

  initial begin
    sweep_exp = '{16'h1333, 16'h1135, 16'h0034, 16'h12FF,
                  16'hEDCB, 16'h0000, 16'h1234, 16'h1234};
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Single request: 5 + 3.
    run_op(1'b0, 3'b000, 16'h0005, 16'h0003, 16'h0008, "single");

    // Contention: both valid continuously, fresh reset so port 0 goes first.
    do_reset();
    begin
      int  n;
      bit  both_hi;
      n = 0;
      both_hi = 1'b0;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 16'h0000; bus.req0_b = 16'h0001;
      bus.req1_valid = 1'b1; bus.req1_op = 3'b010; bus.req1_a = 16'hF0F0; bus.req1_b = 16'h0FF0;
      for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
        #1;
        if (bus.req0_ready && bus.req1_ready) both_hi = 1'b1;
        if (bus.rsp_valid) begin
          check("cont_id", 16'(bus.rsp_id), 16'(n % 2));
          check("cont_data", bus.rsp_data, (n % 2 == 1) ? 16'h00F0 : 16'hFFFF);
          n++;
        end
        @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("cont_count", 16'(n), 16'd4);
      check("cont_one_ready", 16'(both_hi), 16'h0);
      for (int w = 0; w < 10 && busy; w++) @(negedge clk);
      check("cont_drain", 16'(busy), 16'h0);
    end

    // Backpressure on a port-1 NOT, with port 0 waiting behind it.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b100; bus.req1_a = 16'h00FF; bus.req1_b = 16'h0000;
    #1;
    check("bp_rdy1", 16'(bus.req1_ready), 16'h1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req1_a = 16'h1234;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 16'h0010; bus.req0_b = 16'h0020;
    #1;
    check("bp_exec_rdy0", 16'(bus.req0_ready), 16'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("bp_vld", 16'(bus.rsp_valid), 16'h1);
      check("bp_data", bus.rsp_data, 16'hFF00);
      check("bp_id", 16'(bus.rsp_id), 16'h1);
      check("bp_rdy0", 16'(bus.req0_ready), 16'h0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_next_rdy0", 16'(bus.req0_ready), 16'h1);
    check("bp_next_rdy1", 16'(bus.req1_ready), 16'h0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("bp_next_vld", 16'(bus.rsp_valid), 16'h1);
    check("bp_next_data", bus.rsp_data, 16'h0030);
    check("bp_next_id", 16'(bus.rsp_id), 16'h0);
    @(negedge clk);

    // Op sweep on port 0.
    for (int i = 0; i < 8; i++)
      run_op(1'b0, 3'(i), 16'h1234, 16'h00FF, sweep_exp[i], "sweep");

    // Reset while in EXEC: op discarded, last restored to 1.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("rmid_in_exec", 16'(busy), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rmid_busy", 16'(busy), 16'h0);
    check("rmid_vld", 16'(bus.rsp_valid), 16'h0);
    check("rmid_data", bus.rsp_data, 16'h0000);
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 16'h0002; bus.req0_b = 16'h0003;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b011; bus.req1_a = 16'h0F00; bus.req1_b = 16'h00F0;
    #1;
    check("rmid_rst_rdy0", 16'(bus.req0_ready), 16'h0);
    check("rmid_rst_rdy1", 16'(bus.req1_ready), 16'h0);
    @(negedge clk);
    check("rmid_no_accept", 16'(busy), 16'h0);
    rst = 1'b0;
    #1;
    check("rmid_win_rdy0", 16'(bus.req0_ready), 16'h1);
    check("rmid_win_rdy1", 16'(bus.req1_ready), 16'h0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("rmid_post_vld", 16'(bus.rsp_valid), 16'h1);
    check("rmid_post_data", bus.rsp_data, 16'h0005);
    check("rmid_post_id", 16'(bus.rsp_id), 16'h0);
    @(negedge clk);

    // Grant counters: 3 port-0 grants, 2 port-1 grants from reset.
    do_reset();
    for (int i = 0; i < 3; i++) run_op(1'b0, 3'b000, 16'h0001, 16'h0001, 16'h0002, "stat0");
    for (int i = 0; i < 2; i++) run_op(1'b1, 3'b011, 16'h00F0, 16'h000F, 16'h00FF, "stat1");
`ifdef ALU_ARB_STATS_EN
    check("stat_gc0", gc0, 16'd3);
    check("stat_gc1", gc1, 16'd2);
    @(negedge clk);
    force dut.grant_cnt0_q = 16'hFFFF;
    @(negedge clk);
    release dut.grant_cnt0_q;
    check("sat_pre", gc0, 16'hFFFF);
    run_op(1'b0, 3'b000, 16'h0001, 16'h0001, 16'h0002, "sat");
    check("sat_gc0", gc0, 16'hFFFF);
    check("sat_gc1", gc1, 16'd2);
`else
    check("stat_gc0", gc0, 16'd0);
    check("stat_gc1", gc1, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
